// File: rtl/prescaler_bank.sv
// Bank of independent programmable clock prescalers with synchronised enables,
// shadowed divide/mode settings and a shared phase-realign strobe.
module prescaler_bank #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ena,
    input  logic [N_CH*CNT_W-1:0]   div_val,
    input  logic [N_CH-1:0]         mode,
    input  logic                    realign,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         active
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   ena_s;
        logic [CNT_W-1:0]       d_in;
        logic [CNT_W-1:0]       cnt_r;
        logic [CNT_W-1:0]       d_sh_r;
        logic                   m_sh_r;
        logic                   clk_r;
        logic                   tick_r;

        assign ena_s = sync_r[SYNC_STAGES-1];
        assign d_in  = div_val[i*CNT_W +: CNT_W];

        // Enable synchroniser; its last stage is the channel's only view of ena.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_r <= '0;
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], ena[i]};
            end
        end

        // Divider core: the shadow registers only reload at a period boundary,
        // so a running period always completes with the settings it started with.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r  <= '0;
                d_sh_r <= '0;
                m_sh_r <= 1'b0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (!ena_s) begin
                cnt_r  <= '0;
                d_sh_r <= d_in;
                m_sh_r <= mode[i];
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (realign) begin
                cnt_r  <= '0;
                d_sh_r <= d_in;
                m_sh_r <= mode[i];
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
            end else if (cnt_r == d_sh_r) begin
                cnt_r  <= '0;
                d_sh_r <= d_in;
                m_sh_r <= mode[i];
                clk_r  <= m_sh_r ? 1'b1 : ~clk_r;
                tick_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + CNT_ONE;
                d_sh_r <= d_sh_r;
                m_sh_r <= m_sh_r;
                clk_r  <= m_sh_r ? 1'b0 : clk_r;
                tick_r <= 1'b0;
            end
        end

        assign clk_out[i] = clk_r;
        assign tick[i]    = tick_r;
        assign active[i]  = ena_s;
    end

endmodule
